parity_step_counter: RTL
========================

Name: parity_step_counter

Overview:
Parametrised parity-filtered step counter, the next generation of the team's even/odd counter. It counts up or down by STEP while keeping the count on even, odd or any values. A small FSM tracks IDLE, RUN and HALT states. Each step checks a programmable limit and either wraps or saturates. Loads are validated against parity, and the block reports terminal-count and load-error pulses. It sits in the datapath wherever a sequenced even/odd address or index stream is required.

Parameters:
WIDTH, 8, counter, data_in and limit width (>=2)
STEP, 2, increment/decrement magnitude; must be even, >=2, < 2**WIDTH (elaboration check)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  step enable
load  input  1  load request for data_in
mode  input  2  00 EVEN, 01 ODD, 10 ANY, 11 HOLD
dir  input  1  0 count up, 1 count down
sat  input  1  1 saturate-and-halt at boundary, 0 wrap
data_in  input  WIDTH  load value
limit  input  WIDTH  upper bound (inclusive)
count  output  WIDTH  current count (registered)
tc  output  1  one-cycle pulse on any boundary event
load_err  output  1  one-cycle pulse when a load is rejected
busy  output  1  state==RUN
halted  output  1  state==HALT

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On the cycle after rst: count=0, tc=0, load_err=0, state IDLE. rst overrides all other inputs.
- Priority each cycle: rst > load > en. No input is ever combinationally reflected to outputs; all outputs are registered, with 1-cycle latency.
- base(mode): EVEN=0, ODD=1, ANY=0. Parity match: EVEN requires data[0]==0, ODD requires data[0]==1, ANY always matches, HOLD never matches.
- Load, any state:
  - If parity matches: count<=data_in, state<=RUN.
  - Otherwise: count unchanged, state unchanged, load_err=1 for that cycle.
  - data_in > limit is still accepted; the next up-step then triggers a boundary.
- HOLD (mode 11): count frozen, en ignored, loads rejected with load_err. State is retained.
- IDLE with en=1 (no load): count<=base(mode), state<=RUN. IDLE with en=0: hold.
- RUN with en=1, when mode is EVEN/ODD and count[0] mismatches (mode changed mid-run), this is an align step:
  - dir=0: count+1.
  - dir=1: count-1.
  - Boundary rules below apply using a delta of 1.
- RUN with en=1 and parity already correct: normal step of ±STEP.
- Boundary arithmetic uses WIDTH+1 bits, with no silent modulo-2**WIDTH overflow.
  - Up boundary: count+delta > limit.
  - Down boundary: count < base+delta.
- Boundary with sat=1: count holds, tc=1, state<=HALT.
- Boundary with sat=0: tc=1, state stays RUN.
  - Up wraps to base(mode).
  - Down wraps to top = limit, minus 1 if limit parity mismatches mode (ANY: top=limit).
- If limit < base, every enabled step is a boundary event.
- HALT: en ignored; count holds. Exits only via an accepted load (to RUN) or rst.
- tc and load_err are mutually exclusive, since load beats en. Both deassert the cycle after a pulse unless re-triggered.
- busy and halted are decoded directly from the state register; they are never both 1.

Test Plan:
1. WIDTH=8, STEP=2. RUN with count=0x24, assert rst one cycle -> next cycle count=0, IDLE, busy=0, tc=0, load_err=0.
2. mode=EVEN, load data_in=7 -> load_err pulse, count unchanged; then load 6 -> count=6, busy=1. Same cycle as en=1: load wins, count=6.
3. mode=EVEN, sat=0, limit=10, count=8, en -> count=10, tc=0; next en -> count=0, tc=1 for one cycle, busy=1.
4. mode=ODD, sat=1, limit=9, count=9, en -> count=9, tc=1, halted=1; 3 more en -> no change; load 3 -> count=3, busy=1.
5. RUN, mode=EVEN, count=6, switch to ODD, dir=0, en x2 -> count 7 (align), then 9. Mode=HOLD: en -> no change; load 5 -> load_err.
6. mode=ODD, dir=1, sat=0, limit=0x0E, count=1, en -> count=13, tc=1. Then IDLE after rst, mode=ODD, en -> count=1, busy=1.

Source files
------------

// File: rtl/parity_step_counter_if.sv
// Control/status bundle for parity_step_counter: step controls, load path and
// registered status outputs. The master side drives controls; the counter is the slave.
interface parity_step_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [1:0]       mode;
  logic             dir;
  logic             sat;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             load_err;
  logic             busy;
  logic             halted;

  modport master (
    output en, load, mode, dir, sat, data_in, limit,
    input  count, tc, load_err, busy, halted
  );

  modport slave (
    input  en, load, mode, dir, sat, data_in, limit,
    output count, tc, load_err, busy, halted
  );
endinterface

// File: rtl/parity_step_counter.sv
// Parity-filtered up/down step counter with programmable inclusive limit,
// wrap or saturate-and-halt at the boundary, and parity-checked loads.
module parity_step_counter #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
) (
  input logic                  clk,
  input logic                  rst,
  parity_step_counter_if.slave bus
);

  if (WIDTH < 2) begin : g_width_chk
    $error("parity_step_counter: WIDTH must be >= 2");
  end
  if ((STEP % 2) != 0 || STEP < 2 || STEP >= (2 ** WIDTH)) begin : g_step_chk
    $error("parity_step_counter: STEP must be even, >= 2 and < 2**WIDTH");
  end

  typedef enum logic [1:0] {MODE_EVEN, MODE_ODD, MODE_ANY, MODE_HOLD} mode_t;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [WIDTH:0] STEP_X = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0] ONE_X  = (WIDTH + 1)'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] count, count_n;
  logic             tc, tc_n;
  logic             load_err, load_err_n;

  mode_t            md;
  logic             is_odd;
  logic             parity_mode;
  logic             match;
  logic             align;
  logic [WIDTH:0]   cnt_x, lim_x, base_x, delta, sum;
  logic             up_bnd, dn_bnd, bnd;
  logic [WIDTH-1:0] top;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      tc       <= tc_n;
      load_err <= load_err_n;
    end
  end

  // Boundary arithmetic in WIDTH+1 bits so an up-step past 2**WIDTH-1 is seen
  always_comb begin
    md          = mode_t'(bus.mode);
    is_odd      = (md == MODE_ODD);
    parity_mode = (md == MODE_EVEN) || (md == MODE_ODD);
    cnt_x       = {1'b0, count};
    lim_x       = {1'b0, bus.limit};
    base_x      = {{WIDTH{1'b0}}, is_odd};
    align       = parity_mode && (count[0] != is_odd);
    delta       = align ? ONE_X : STEP_X;
    sum         = cnt_x + delta;
    up_bnd      = sum > lim_x;
    dn_bnd      = cnt_x < (base_x + delta);
    bnd         = bus.dir ? dn_bnd : up_bnd;
    top         = bus.limit - WIDTH'(parity_mode && (bus.limit[0] != is_odd));
    unique case (md)
      MODE_EVEN: match = ~bus.data_in[0];
      MODE_ODD:  match = bus.data_in[0];
      MODE_ANY:  match = 1'b1;
      default:   match = 1'b0;
    endcase
  end

  // Next state: load beats en; HOLD mode freezes stepping and rejects loads
  always_comb begin
    state_n    = state;
    count_n    = count;
    tc_n       = 1'b0;
    load_err_n = 1'b0;
    if (bus.load) begin
      if (match) begin
        count_n = bus.data_in;
        state_n = RUN;
      end else begin
        load_err_n = 1'b1;
      end
    end else if (bus.en && md != MODE_HOLD) begin
      unique case (state)
        IDLE: begin
          count_n = base_x[WIDTH-1:0];
          state_n = RUN;
        end
        RUN: begin
          if (bnd) begin
            tc_n = 1'b1;
            if (bus.sat) state_n = HALT;
            else         count_n = bus.dir ? top : base_x[WIDTH-1:0];
          end else begin
            count_n = bus.dir ? (count - delta[WIDTH-1:0]) : sum[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.count    = count;
  assign bus.tc       = tc;
  assign bus.load_err = load_err;
  assign bus.busy     = (state == RUN);
  assign bus.halted   = (state == HALT);

endmodule
